stage5mo: RTL
=============

# stage5mo

Memory-operation stage of the 12-bit diad pipeline. It sits directly downstream of the memory-address stage and upstream of write-back. It performs the data-memory load or store for LD/LDi/ST/STi through a variable-latency req/ack port, and stalls upstream while a transaction is outstanding. For all other instructions it forwards PC, instruction, result and flags through a single pipeline latch.

## Interface
Parameters:
- MAX_WAIT, default 15: maximum number of cycles in BUSY before the stage aborts the access (4-bit counter).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable_in  in  1  upstream stage output valid
- instr_set_in  in  2  instruction-set selector (`ISET_*`)
- pc_in  in  12  PC, already branch-resolved
- instr_in  in  12  instruction word; opcode is [11:8]
- result_in  in  12  ALU result; this is the data address for memory instructions
- store_data_in  in  12  store data
- flags_in  in  4  flags
- stall_out  out  1  upstream must hold its outputs stable while high
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  12  memory address
- dmem_wdata  out  12  store data
- dmem_rdata  in  12  load data, valid with ack
- dmem_ack  in  1  transaction complete; one-cycle pulse
- enable_out  out  1  downstream valid; one-cycle pulse per retired instruction
- pc_out, instr_out, result_out  out  12 each  latched to write-back
- flags_out  out  4  latched flags
- bus_err_out  out  1  sticky timeout error

## Operation
- mem_instr is the combinational decode of {instr_set_in, opcode} against {ISET_R,OPC_R_LD}, {ISET_I,OPC_I_LDi}, {ISET_R,OPC_R_ST} and {ISET_I,OPC_I_STi}. is_store covers the two ST cases.
- FSM states: IDLE and BUSY.
- IDLE, enable_in=1, mem_instr=0: the output latch loads pc_in, instr_in, result_in and flags_in. enable_out is 1 in the next cycle.
- IDLE, enable_in=1, mem_instr=1:
  - The hold registers capture pc, instr, flags, address (result_in), wdata and we.
  - State goes to BUSY and the timeout counter clears.
  - The output latch is not updated, and enable_out is 0 next cycle.
- BUSY:
  - dmem_req=1; dmem_addr, dmem_we and dmem_wdata come from the hold registers and stay stable.
  - stall_out=1; enable_in is ignored.
  - The counter increments each cycle.
- BUSY with dmem_ack=1:
  - The output latch loads from the hold registers.
  - result_out is dmem_rdata for a load and the held address for a store.
  - enable_out is 1 in the next cycle, and state returns to IDLE.
- BUSY with no ack and counter == MAX_WAIT-1:
  - The access is aborted and the stage completes as on ack, except result_out = 12'hFFF for both loads and stores.
  - bus_err_out goes to 1 and stays set until rst.
  - A late ack arriving in IDLE is ignored.
- dmem_ack in IDLE is ignored.
- dmem_req, dmem_we, dmem_addr and dmem_wdata are all driven from registers; they are 0 in IDLE.
- flags pass through unchanged; this stage never modifies flags.
- When enable_in=0 in IDLE, the output latch holds its value and enable_out is 0.

## Timing
- Reset values: all output latches 0, enable_out 0, stall_out 0, dmem_* outputs 0, bus_err_out 0, state IDLE, counter 0.
- rst during BUSY aborts immediately: dmem_req drops asynchronously and no retirement occurs. The memory must tolerate a dropped request.
- Non-memory instruction latency: 1 cycle (enable_in at edge N gives enable_out high in cycle N+1).
- Memory instruction latency: accept at edge N, dmem_req high from N+1; ack at edge N+k (k ≥ 1) gives enable_out high in cycle N+k+1. Minimum total latency is 2 cycles.
- stall_out = (state == BUSY), driven from a register.
  - Upstream advances on the accept edge.
  - The next instruction is presented during BUSY and held.
  - That instruction is accepted on the first IDLE cycle after completion.
- Back-to-back loads therefore retire at most every 2 cycles.
- An ack and a timeout in the same cycle: the ack wins, and no error is flagged.

## Structure
- ISET_* and OPC_* come from iset.vh and opcodes.vh; no new constants are needed.
- The ISET/opcode decode is shared with the address stage. It moves to a small shared submodule, mem_decode (outputs: mem_instr, is_store, is_load), which both stages instantiate.
- The FSM, hold registers and output latch are inline in stage5mo.

## Test plan
- Reset, then non-memory instr (ISET_R, non-LD/ST) with result_in=12'h123, enable_in pulse → next cycle enable_out=1, result_out=12'h123, stall_out=0, dmem_req never high.
- LD with result_in=12'h040; memory acks 3 cycles later with rdata=12'hABC → dmem_addr=12'h040 and dmem_we=0 stable for 3 cycles, stall_out high for 3 cycles, enable_out=1 one cycle after ack, result_out=12'hABC.
- STi with result_in=12'h07F, store_data_in=12'h5A5, ack after 1 cycle → dmem_we=1 and dmem_wdata=12'h5A5 during req, result_out=12'h07F, total latency 2 cycles.
- LD followed immediately by ADD presented during BUSY → ADD held by upstream, accepted after LD retires; outputs in order LD then ADD, each with a single enable_out pulse.
- LD with no ack, MAX_WAIT=15 → req drops after 15 BUSY cycles, result_out=12'hFFF, bus_err_out stays 1; a later ack is ignored and the next non-memory instr retires normally.
- rst asserted in the second BUSY cycle → dmem_req=0 and all outputs 0 immediately, no enable_out pulse, and the stage accepts a new instruction after rst deasserts.

Source files
------------

// File: rtl/stage5mo_pkg.sv
// Shared constants and types for the memory-operation stage of the 12-bit diad pipeline.
package stage5mo_pkg;

  localparam logic [1:0] ISET_R = 2'd0;
  localparam logic [1:0] ISET_I = 2'd1;

  localparam logic [3:0] OPC_R_LD  = 4'hC;
  localparam logic [3:0] OPC_R_ST  = 4'hD;
  localparam logic [3:0] OPC_I_LDi = 4'hC;
  localparam logic [3:0] OPC_I_STi = 4'hD;

  localparam int          CNT_W        = 4;
  localparam logic [11:0] RESULT_ABORT = 12'hFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mem_decode.sv
// Load/store decode of {instruction set, opcode}; shared by the address and memory stages.
module mem_decode
  import stage5mo_pkg::*;
(
  input  logic [1:0] instr_set_i,
  input  logic [3:0] opcode_i,
  output logic       mem_instr_o,
  output logic       is_store_o,
  output logic       is_load_o
);

  assign is_load_o  = ((instr_set_i == ISET_R) && (opcode_i == OPC_R_LD)) ||
                      ((instr_set_i == ISET_I) && (opcode_i == OPC_I_LDi));
  assign is_store_o = ((instr_set_i == ISET_R) && (opcode_i == OPC_R_ST)) ||
                      ((instr_set_i == ISET_I) && (opcode_i == OPC_I_STi));
  assign mem_instr_o = is_load_o | is_store_o;

endmodule

// File: rtl/stage5mo.sv
// Memory-operation stage: performs loads/stores over a req/ack port with timeout,
// stalling upstream while busy; other instructions pass through one latch.
module stage5mo
  import stage5mo_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_in,
  input  logic [1:0]  instr_set_in,
  input  logic [11:0] pc_in,
  input  logic [11:0] instr_in,
  input  logic [11:0] result_in,
  input  logic [11:0] store_data_in,
  input  logic [3:0]  flags_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [11:0] dmem_addr,
  output logic [11:0] dmem_wdata,
  input  logic [11:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        enable_out,
  output logic [11:0] pc_out,
  output logic [11:0] instr_out,
  output logic [11:0] result_out,
  output logic [3:0]  flags_out,
  output logic        bus_err_out
);

  logic mem_instr, is_store, is_load;

  mem_decode u_mem_decode (
    .instr_set_i (instr_set_in),
    .opcode_i    (instr_in[11:8]),
    .mem_instr_o (mem_instr),
    .is_store_o  (is_store),
    .is_load_o   (is_load)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               stall_q, stall_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [11:0]        addr_q, addr_d;
  logic [11:0]        wdata_q, wdata_d;
  logic               hold_load_q, hold_load_d;
  logic [11:0]        hold_pc_q, hold_pc_d;
  logic [11:0]        hold_instr_q, hold_instr_d;
  logic [3:0]         hold_flags_q, hold_flags_d;
  logic               en_q, en_d;
  logic [11:0]        pc_q, pc_d;
  logic [11:0]        instr_q, instr_d;
  logic [11:0]        result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic               bus_err_q, bus_err_d;

  logic timeout;
  assign timeout = (cnt_q == CNT_W'(MAX_WAIT - 1));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_d      = stall_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    hold_load_d  = hold_load_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    hold_flags_d = hold_flags_q;
    en_d         = 1'b0;
    pc_d         = pc_q;
    instr_d      = instr_q;
    result_d     = result_q;
    flags_d      = flags_q;
    bus_err_d    = bus_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable_in && mem_instr) begin
          state_d      = ST_BUSY;
          cnt_d        = '0;
          stall_d      = 1'b1;
          req_d        = 1'b1;
          we_d         = is_store;
          addr_d       = result_in;
          wdata_d      = store_data_in;
          hold_load_d  = is_load;
          hold_pc_d    = pc_in;
          hold_instr_d = instr_in;
          hold_flags_d = flags_in;
        end else if (enable_in) begin
          en_d     = 1'b1;
          pc_d     = pc_in;
          instr_d  = instr_in;
          result_d = result_in;
          flags_d  = flags_in;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // Ack takes priority over a coincident timeout.
        if (dmem_ack || timeout) begin
          state_d = ST_IDLE;
          stall_d = 1'b0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          en_d    = 1'b1;
          pc_d    = hold_pc_q;
          instr_d = hold_instr_q;
          flags_d = hold_flags_q;
          if (!dmem_ack) begin
            result_d  = RESULT_ABORT;
            bus_err_d = 1'b1;
          end else begin
            result_d = hold_load_q ? dmem_rdata : addr_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      stall_q      <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      hold_load_q  <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      hold_flags_q <= '0;
      en_q         <= 1'b0;
      pc_q         <= '0;
      instr_q      <= '0;
      result_q     <= '0;
      flags_q      <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stall_q      <= stall_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      hold_load_q  <= hold_load_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_flags_q <= hold_flags_d;
      en_q         <= en_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign stall_out   = stall_q;
  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign enable_out  = en_q;
  assign pc_out      = pc_q;
  assign instr_out   = instr_q;
  assign result_out  = result_q;
  assign flags_out   = flags_q;
  assign bus_err_out = bus_err_q;

endmodule
